// File: rtl/hynoc_ni_packetizer.sv
// Network-interface packetizer: command + payload stream in, router flits out.
// Header flits open a channel; a flit with the MSB set closes it.

module hynoc_ni_packetizer #(
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
  parameter int MAX_HEADERS     = 4,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                                 ni_clk,
  input  logic                                 ni_arst_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [$clog2(MAX_HEADERS):0]         cmd_nb_headers,
  input  logic [MAX_HEADERS*PAYLOAD_WIDTH-1:0] cmd_headers,
  input  logic [LEN_WIDTH-1:0]                 cmd_length,
  input  logic                                 cmd_keep_open,
  input  logic                                 pld_valid,
  output logic                                 pld_ready,
  input  logic [PAYLOAD_WIDTH-1:0]             pld_data,
  output logic                                 egress_write,
  output logic [FLIT_WIDTH-1:0]                egress_data,
  input  logic [LOG2_FIFO_DEPTH:0]             egress_fifo_level,
  output logic                                 chan_open,
  output logic                                 busy
);

  localparam int NBW = $clog2(MAX_HEADERS) + 1;
  localparam int HW  = MAX_HEADERS * PAYLOAD_WIDTH;

  localparam logic [NBW-1:0] NB_ONE = NBW'(1);
  localparam logic [NBW-1:0] NB_MAX = NBW'(MAX_HEADERS);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LOG2_FIFO_DEPTH:0] SEND_LIM =
    (LOG2_FIFO_DEPTH+1)'((1 << LOG2_FIFO_DEPTH) - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CLOSE
  } state_e;

  state_e                  state_q, state_d;
  logic                    rst_q;
  logic [HW-1:0]           hdr_q, hdr_d;
  logic [NBW-1:0]          nb_q, nb_d;
  logic [NBW-1:0]          idx_q, idx_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    keep_q, keep_d;
  logic                    wr_q, wr_d;
  logic [FLIT_WIDTH-1:0]   data_q, data_d;
  logic                    open_q, open_d;

  logic                    can_send;
  logic                    last;
  logic                    close;
  logic [NBW-1:0]          nb_in;
  logic [PAYLOAD_WIDTH-1:0] hdr_sel;

  assign can_send     = egress_fifo_level < SEND_LIM;
  assign last         = cnt_q == len_q - LEN_ONE;
  assign close        = last & ~keep_q;
  assign egress_write = wr_q;
  assign egress_data  = data_q;
  assign chan_open    = open_q;
  assign busy         = state_q != S_IDLE;

  always_comb begin
    nb_in = cmd_nb_headers;
    if (cmd_nb_headers == '0) begin
      nb_in = NB_ONE;
    end else if (cmd_nb_headers > NB_MAX) begin
      nb_in = NB_MAX;
    end
  end

  always_comb begin
    hdr_sel = '0;
    for (int i = 0; i < MAX_HEADERS; i++) begin
      if (idx_q == NBW'(i)) begin
        hdr_sel = hdr_q[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    nb_d      = nb_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    keep_d    = keep_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    open_d    = open_q;
    cmd_ready = 1'b0;
    pld_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rst_q holds off acceptance until one edge after reset release
        cmd_ready = rst_q;
        if (cmd_valid && rst_q) begin
          hdr_d  = cmd_headers;
          nb_d   = nb_in;
          len_d  = cmd_length;
          keep_d = cmd_keep_open;
          idx_d  = '0;
          cnt_d  = '0;
          if (!open_q) begin
            state_d = S_HEADER;
          end else if (cmd_length != '0) begin
            state_d = S_PAYLOAD;
          end else if (!cmd_keep_open) begin
            state_d = S_CLOSE;
          end
        end
      end

      S_HEADER: begin
        if (can_send) begin
          wr_d   = 1'b1;
          data_d = FLIT_WIDTH'({1'b0, hdr_sel});
          open_d = 1'b1;
          idx_d  = idx_q + NB_ONE;
          if (idx_q == nb_q - NB_ONE) begin
            if (len_q != '0) begin
              state_d = S_PAYLOAD;
            end else if (keep_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_CLOSE;
            end
          end
        end
      end

      S_PAYLOAD: begin
        pld_ready = can_send;
        if (pld_valid && can_send) begin
          wr_d   = 1'b1;
          data_d = FLIT_WIDTH'({close, pld_data});
          cnt_d  = cnt_q + LEN_ONE;
          if (close) begin
            open_d = 1'b0;
          end
          if (last) begin
            state_d = S_IDLE;
          end
        end
      end

      S_CLOSE: begin
        if (can_send) begin
          wr_d    = 1'b1;
          data_d  = FLIT_WIDTH'({1'b1, {PAYLOAD_WIDTH{1'b0}}});
          open_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ni_clk or negedge ni_arst_n) begin
    if (!ni_arst_n) begin
      state_q <= S_IDLE;
      rst_q   <= 1'b0;
      hdr_q   <= '0;
      nb_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      keep_q  <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b1;
      hdr_q   <= hdr_d;
      nb_q    <= nb_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      keep_q  <= keep_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      open_q  <= open_d;
    end
  end

endmodule

// File: tb/tb_hynoc_ni_packetizer.sv
// Bench for hynoc_ni_packetizer: packet-level flit model plus directed
// literal checks, with randomized payload rate and router back-pressure.

module tb_hynoc_ni_packetizer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_nb = '0;
  logic [127:0] cmd_hdr = '0;
  logic [15:0]  cmd_len = '0;
  logic         cmd_keep = 1'b0;
  logic         pld_valid = 1'b0;
  logic         pld_ready;
  logic [31:0]  pld_data = '0;
  logic         egress_write;
  logic [32:0]  egress_data;
  logic [5:0]   level = '0;
  logic         chan_open;
  logic         busy;

  hynoc_ni_packetizer dut (
    .ni_clk            (clk),
    .ni_arst_n         (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_nb_headers    (cmd_nb),
    .cmd_headers       (cmd_hdr),
    .cmd_length        (cmd_len),
    .cmd_keep_open     (cmd_keep),
    .pld_valid         (pld_valid),
    .pld_ready         (pld_ready),
    .pld_data          (pld_data),
    .egress_write      (egress_write),
    .egress_data       (egress_data),
    .egress_fifo_level (level),
    .chan_open         (chan_open),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [32:0] flit;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] drv_pld[$];
  logic [31:0] mdl_pld[$];
  logic [31:0] next_words[$];
  logic [32:0] obs[$];
  int          obs_cyc[$];

  int          n_asrt = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          force_lvl = 0;
  int          pv_pct = 100;
  bit          mdl_open = 1'b0;
  bit          pending = 1'b0;
  bit          xfer_seen = 1'b0;
  bit          prev_can = 1'b1;
  bit          armed = 1'b0;
  logic [31:0] pend_data = '0;
  exp_t        e;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_asrt++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_asrt++;
    n_fail++;
    $display("FAIL %s: actual expired required completed", nm);
  endfunction

  function automatic logic [32:0] ob(int k);
    if (k >= 0 && k < obs.size()) return obs[k];
    return 'x;
  endfunction

  function automatic int obc(int k);
    if (k >= 0 && k < obs_cyc.size()) return obs_cyc[k];
    return -1;
  endfunction

  // Whole packet as the router must see it, built when the command is taken
  function automatic void accept();
    logic [32:0] fl[$];
    int nb;
    int len;
    nb  = (cmd_nb == 0) ? 1 : ((cmd_nb > 4) ? 4 : int'(cmd_nb));
    len = int'(cmd_len);
    if (!mdl_open) begin
      for (int i = 0; i < nb; i++) fl.push_back({1'b0, cmd_hdr[i*32 +: 32]});
    end
    for (int j = 0; j < len; j++) begin
      logic [31:0] w;
      w = (mdl_pld.size() > 0) ? mdl_pld.pop_front() : 32'h0;
      fl.push_back({(j == len - 1) && !cmd_keep, w});
    end
    if (len == 0 && !cmd_keep) fl.push_back({1'b1, 32'h0});
    for (int k = 0; k < fl.size(); k++) begin
      exp_t x;
      x.flit = fl[k];
      x.last = (k == fl.size() - 1);
      exp_q.push_back(x);
    end
    mdl_open = cmd_keep;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pending   = 1'b0;
      xfer_seen = 1'b0;
      prev_can  = 1'b1;
    end else begin
      cyc++;
      if (armed) chk("cmd_ready_vs_busy", cmd_ready, !busy);
      if (pld_ready) chk("pld_ready_space", level < 30, 1);
      if (pending) begin
        chk("xfer_latency_write", egress_write, 1);
        if (egress_write) chk("xfer_latency_data", egress_data[31:0], pend_data);
      end
      if (egress_write) begin
        obs.push_back(egress_data);
        obs_cyc.push_back(cyc);
        chk("write_needs_space", prev_can, 1);
        if (exp_q.size() == 0) begin
          n_asrt++;
          n_fail++;
          $display("FAIL spurious_flit: actual %0h required none", egress_data);
        end else begin
          e = exp_q.pop_front();
          chk("flit", egress_data, e.flit);
          chk("chan_open_flit", chan_open, !e.flit[32]);
          if (e.last) chk("idle_after_last", busy, 0);
        end
      end else if (exp_q.size() == 0 && !busy) begin
        chk("chan_open_idle", chan_open, mdl_open);
      end
      if (cmd_valid && cmd_ready) accept();
      xfer_seen = pld_valid && pld_ready;
      pending   = xfer_seen;
      pend_data = pld_data;
      prev_can  = level < 30;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (xfer_seen && drv_pld.size() > 0) void'(drv_pld.pop_front());
      if (drv_pld.size() > 0 && $urandom_range(1, 100) <= pv_pct) begin
        pld_valid = 1'b1;
        pld_data  = drv_pld[0];
      end else begin
        pld_valid = 1'b0;
        pld_data  = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (force_lvl >= 0) level = 6'(force_lvl);
      else if ($urandom_range(0, 9) < 2) level = 6'($urandom_range(28, 32));
      else level = 6'($urandom_range(0, 27));
    end
  end

  task automatic send(input int nb, input logic [127:0] hdr,
                      input int len, input bit keep);
    bit acc;
    logic [31:0] w;
    acc = 1'b0;
    for (int i = 0; i < len; i++) begin
      w = (next_words.size() > 0) ? next_words.pop_front() : $urandom;
      drv_pld.push_back(w);
      mdl_pld.push_back(w);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_nb    = 3'(nb);
    cmd_hdr   = hdr;
    cmd_len   = 16'(len);
    cmd_keep  = keep;
    for (int c = 0; c < 3000 && !acc; c++) begin
      @(negedge clk);
      #1;
      if (cmd_ready) acc = 1'b1;
    end
    if (!acc) fail_now("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_nb    = 3'($urandom);
    cmd_hdr   = {$urandom, $urandom, $urandom, $urandom};
    cmd_len   = 16'($urandom);
    cmd_keep  = 1'($urandom);
  endtask

  task automatic wait_idle(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic wait_obs(input int n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk);
      if (obs.size() >= n) ok = 1'b1;
    end
    if (!ok) fail_now("flit_wait_timeout");
  endtask

  initial begin
    int b;
    int b2;
    int n1;
    int cnt;
    rst_n = 1'b0;
    force_lvl = 0;
    pv_pct = 100;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", egress_write, 0);
    chk("rst_data", egress_data, 0);
    chk("rst_open", chan_open, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pld_ready", pld_ready, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", cmd_ready, 1);

    b = obs.size();
    next_words = {32'hCAFE_DECA};
    send(1, 128'h2B2, 1, 0);
    wait_idle(200);
    chk("basic_hdr", ob(b), 33'h0_0000_02B2);
    chk("basic_pld", ob(b + 1), 33'h1_CAFE_DECA);
    chk("basic_consecutive", obc(b + 1) - obc(b), 1);
    chk("basic_closed", chan_open, 0);

    b = obs.size();
    next_words = {32'h0123_4567, 32'h89AB_CDEF};
    send(3, {32'h0, 32'h30, 32'h20, 32'h20}, 2, 0);
    wait_idle(200);
    chk("three_h0", ob(b), 33'h0_0000_0020);
    chk("three_h1", ob(b + 1), 33'h0_0000_0020);
    chk("three_h2", ob(b + 2), 33'h0_0000_0030);
    chk("three_p0", ob(b + 3), 33'h0_0123_4567);
    chk("three_p1", ob(b + 4), 33'h1_89AB_CDEF);

    b = obs.size();
    send(1, 128'hA1, 3, 1);
    wait_idle(200);
    chk("keep_open_kept", chan_open, 1);
    send(2, {32'h0, 32'h0, 32'hBB, 32'hCC}, 1, 0);
    wait_idle(200);
    chk("keep_flit_count", obs.size() - b, 5);
    chk("keep_first_hdr", ob(b), 33'h0_0000_00A1);
    for (int k = 1; k < 4; k++) chk("keep_open_msb", ob(b + k) >> 32, 0);
    chk("keep_close_msb", ob(b + 4) >> 32, 1);
    chk("keep_closed", chan_open, 0);

    b = obs.size();
    send(1, 128'h12, 0, 0);
    wait_idle(200);
    chk("len0_hdr", ob(b), 33'h0_0000_0012);
    chk("len0_close", ob(b + 1), 33'h1_0000_0000);

    b = obs.size();
    send(1, 128'h34, 0, 1);
    wait_idle(200);
    chk("len0_keep_count", obs.size() - b, 1);
    chk("len0_keep_hdr", ob(b), 33'h0_0000_0034);
    chk("len0_keep_open", chan_open, 1);
    b2 = obs.size();
    send(1, 128'h56, 0, 1);
    wait_idle(200);
    chk("len0_keep_open_count", obs.size() - b2, 0);
    b2 = obs.size();
    send(1, 128'h78, 0, 0);
    wait_idle(200);
    chk("open_close_count", obs.size() - b2, 1);
    chk("open_close_flit", ob(b2), 33'h1_0000_0000);

    b = obs.size();
    send(0, 128'h9, 1, 0);
    wait_idle(200);
    chk("nb0_count", obs.size() - b, 2);
    b = obs.size();
    send(7, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 0);
    wait_idle(200);
    chk("nb7_count", obs.size() - b, 5);
    chk("nb7_h3", ob(b + 3), 33'h0_0000_0044);

    b = obs.size();
    for (int i = 0; i < 6; i++) next_words.push_back(32'h1000 + i);
    send(1, 128'h9, 6, 0);
    wait_obs(b + 3);
    force_lvl = 30;
    n1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #2;
      chk("stall_pld_ready", pld_ready, 0);
      if (k == 1) n1 = obs.size();
      if (k > 0) chk("stall_no_write", egress_write, 0);
    end
    chk("stall_no_new_flits", obs.size() - n1, 0);
    @(posedge clk);
    force_lvl = 0;
    wait_idle(300);
    for (int i = 0; i < 6; i++) begin
      chk("stall_words", ob(b + 1 + i), {i == 5, 32'h1000 + i});
    end

    b = obs.size();
    send(1, 128'hB16, 65535, 0);
    wait_idle(70000);
    chk("maxlen_count", obs.size() - b, 65536);
    chk("maxlen_close", ob(obs.size() - 1) >> 32, 1);
    chk("maxlen_closed", chan_open, 0);

    pv_pct = 70;
    force_lvl = -1;
    repeat (40) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      send($urandom_range(0, 7), {$urandom, $urandom, $urandom, $urandom},
           len, $urandom_range(0, 3) == 0);
    end
    wait_idle(5000);
    force_lvl = 0;
    pv_pct = 100;

    send(1, 128'h1, 0, 0);
    wait_idle(200);
    chk("pre_reset_closed", chan_open, 0);

    b = obs.size();
    send(1, 128'h55, 8, 0);
    wait_obs(b + 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_write", egress_write, 0);
    chk("midrst_data", egress_data, 0);
    chk("midrst_open", chan_open, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    drv_pld.delete();
    mdl_pld.delete();
    mdl_open = 1'b0;
    pending = 1'b0;
    xfer_seen = 1'b0;
    cnt = 0;
    for (int k = b; k < obs.size(); k++) if (obs[k][32]) cnt++;
    chk("midrst_no_close", cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_after", cmd_ready, 1);
    b2 = obs.size();
    next_words = {32'h0000_BEEF};
    send(1, 128'h77, 1, 0);
    wait_idle(200);
    chk("midrst_new_hdr", ob(b2), 33'h0_0000_0077);
    chk("midrst_new_pld", ob(b2 + 1), 33'h1_0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1, "watchdog");
  end

endmodule
